// File: rtl/sdf_twiddle_mul_pkg.sv
// ---------------------------------------------------------------------------
// sdf_twiddle_mul_pkg
// Shared constants and helpers for the SDF twiddle multiplier slice.
//   DATA_WIDTH_DEF / TW_WIDTH_DEF : default data and twiddle component widths
//   TW_ONE_DEF                    : 1.0 in the default Q2.(TW_WIDTH-2) format
//   log2_f()                      : ceiling log2, usable at elaboration
//   tw_one_f()                    : 1.0 in Q2.(tw_width-2) for any width
// ---------------------------------------------------------------------------
package sdf_twiddle_mul_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int TW_WIDTH_DEF   = 16;
  localparam int TW_ONE_DEF     = 32'sd1 <<< (TW_WIDTH_DEF - 2);

  // Ceiling log2; bounded loop so it folds cleanly as a constant function.
  function automatic int log2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Unity gain expressed in the twiddle Q-format.
  function automatic int tw_one_f(input int tw_width);
    return 32'sd1 <<< (tw_width - 2);
  endfunction

endpackage

// File: rtl/sdf_twiddle_rom.sv
// ---------------------------------------------------------------------------
// sdf_twiddle_rom
// Synchronous-read twiddle ROM holding W_N^e = cos(2*pi*e/N) - i*sin(2*pi*e/N)
// for e = 0 .. FFT_N/2-1, rounded to nearest in Q2.(TW_WIDTH-2). Contents are
// computed at elaboration from FFT_N and TW_WIDTH.
//   clk    in   clock
//   rst    in   synchronous active-high reset (clears the read register)
//   en     in   read enable; the output register holds while low
//   addr   in   twiddle exponent e
//   tw_re  out  registered real part (signed)
//   tw_im  out  registered imaginary part (signed)
// ---------------------------------------------------------------------------
module sdf_twiddle_rom
  import sdf_twiddle_mul_pkg::*;
#(
  parameter int FFT_N      = 64,
  parameter int TW_WIDTH   = TW_WIDTH_DEF,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [TW_WIDTH-1:0]   tw_re,
  output logic [TW_WIDTH-1:0]   tw_im
);

  localparam int  DEPTH = FFT_N / 2;
  localparam real PI    = 3.14159265358979323846;
  localparam real ONE   = real'(tw_one_f(TW_WIDTH));

  logic [TW_WIDTH-1:0] rom_re_s [DEPTH];
  logic [TW_WIDTH-1:0] rom_im_s [DEPTH];

  // Table entries: round-to-nearest of the scaled cos and -sin.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam real ANG   = 2.0 * PI * real'(i) / real'(FFT_N);
    localparam int  C_VAL = $rtoi($floor(ONE * $cos(ANG) + 0.5));
    localparam int  S_VAL = $rtoi($floor(-ONE * $sin(ANG) + 0.5));
    assign rom_re_s[i] = TW_WIDTH'(C_VAL);
    assign rom_im_s[i] = TW_WIDTH'(S_VAL);
  end

  // Registered read, updated only for valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      tw_re <= {TW_WIDTH{1'b0}};
      tw_im <= {TW_WIDTH{1'b0}};
    end else if (en) begin
      tw_re <= rom_re_s[addr];
      tw_im <= rom_im_s[addr];
    end else begin
      tw_re <= tw_re;
      tw_im <= tw_im;
    end
  end

endmodule

// File: rtl/sdf_twiddle_mul.sv
// ---------------------------------------------------------------------------
// sdf_twiddle_mul
// Twiddle multiplier following a radix-2 SDF butterfly stage. Tracks the
// frame position k of each input sample, looks up W_N^e and rotates the
// sample. Fixed 3-cycle latency, no backpressure.
//   clk    in   clock
//   rst    in   synchronous active-high reset; also realigns the frame
//   di_en  in   input sample valid
//   di_re  in   input real part
//   di_im  in   input imaginary part
//   do_en  out  output valid (di_en delayed 3 cycles)
//   do_re  out  output real part (holds while do_en is low)
//   do_im  out  output imaginary part (holds while do_en is low)
//   do_sof out  marks the output carrying frame position k = 0
// Build option: define TWIDDLE_ROUND_EN to round half up before the final
// shift; otherwise the shift truncates toward minus infinity.
// ---------------------------------------------------------------------------
module sdf_twiddle_mul
  import sdf_twiddle_mul_pkg::*;
#(
  parameter int FFT_N      = 64,
  parameter int STAGE      = 0,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TW_WIDTH   = TW_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  di_en,
  input  logic [DATA_WIDTH-1:0] di_re,
  input  logic [DATA_WIDTH-1:0] di_im,
  output logic                  do_en,
  output logic [DATA_WIDTH-1:0] do_re,
  output logic [DATA_WIDTH-1:0] do_im,
  output logic                  do_sof
);

  localparam int KW    = log2_f(FFT_N);
  localparam int AW    = KW - 1;
  localparam int M     = FFT_N >> STAGE;
  localparam int PW    = DATA_WIDTH + TW_WIDTH;
  localparam int SW    = PW + 1;
  localparam int SHIFT = TW_WIDTH - 2;

  // Bit of k that says "second half of the butterfly span", and the mask of
  // the position inside that half.
  localparam logic [KW-1:0] HALF_BIT = KW'(M / 2);
  localparam logic [AW-1:0] LOW_MASK = AW'(M / 2 - 1);

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
`ifdef TWIDDLE_ROUND_EN
  localparam logic signed [SW-1:0] RND = {{(SW - 1){1'b0}}, 1'b1} << (TW_WIDTH - 3);
`else
  localparam logic signed [SW-1:0] RND = {SW{1'b0}};
`endif

  // Clamp a shifted sum into the signed DATA_WIDTH range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_f(input logic signed [SW-1:0] v);
    logic signed [DATA_WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[DATA_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  logic [KW-1:0]                k_r;
  logic [AW-1:0]                tw_addr_s;
  logic [TW_WIDTH-1:0]          tw_re_s;
  logic [TW_WIDTH-1:0]          tw_im_s;
  logic signed [DATA_WIDTH-1:0] a_r;
  logic signed [DATA_WIDTH-1:0] b_r;
  logic                         v1_r;
  logic                         sof1_r;
  logic signed [PW-1:0]         pr_ac_r;
  logic signed [PW-1:0]         pr_bd_r;
  logic signed [PW-1:0]         pr_ad_r;
  logic signed [PW-1:0]         pr_bc_r;
  logic                         v2_r;
  logic                         sof2_r;
  logic signed [SW-1:0]         sum_re_s;
  logic signed [SW-1:0]         sum_im_s;
  logic signed [SW-1:0]         shr_re_s;
  logic signed [SW-1:0]         shr_im_s;

  // Frame position counter; wraps naturally because FFT_N is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r <= {KW{1'b0}};
    end else if (di_en) begin
      k_r <= k_r + KW'(1);
    end else begin
      k_r <= k_r;
    end
  end

  // Exponent: zero in the first half of each span, else the offset into the
  // second half scaled up by the stage's decimation factor.
  always_comb begin
    tw_addr_s = {AW{1'b0}};
    if ((k_r & HALF_BIT) != {KW{1'b0}}) begin
      tw_addr_s = (k_r[AW-1:0] & LOW_MASK) << STAGE;
    end else begin
      tw_addr_s = {AW{1'b0}};
    end
  end

  sdf_twiddle_rom #(
    .FFT_N     (FFT_N),
    .TW_WIDTH  (TW_WIDTH),
    .ADDR_WIDTH(AW)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (di_en),
    .addr (tw_addr_s),
    .tw_re(tw_re_s),
    .tw_im(tw_im_s)
  );

  // P1: capture the input sample alongside the ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= {DATA_WIDTH{1'b0}};
      b_r    <= {DATA_WIDTH{1'b0}};
      v1_r   <= 1'b0;
      sof1_r <= 1'b0;
    end else begin
      v1_r   <= di_en;
      sof1_r <= di_en && (k_r == {KW{1'b0}});
      if (di_en) begin
        a_r <= di_re;
        b_r <= di_im;
      end else begin
        a_r <= a_r;
        b_r <= b_r;
      end
    end
  end

  // P2: four full-width partial products.
  always_ff @(posedge clk) begin
    if (rst) begin
      pr_ac_r <= {PW{1'b0}};
      pr_bd_r <= {PW{1'b0}};
      pr_ad_r <= {PW{1'b0}};
      pr_bc_r <= {PW{1'b0}};
      v2_r    <= 1'b0;
      sof2_r  <= 1'b0;
    end else begin
      v2_r   <= v1_r;
      sof2_r <= sof1_r;
      if (v1_r) begin
        pr_ac_r <= PW'(a_r) * PW'($signed(tw_re_s));
        pr_bd_r <= PW'(b_r) * PW'($signed(tw_im_s));
        pr_ad_r <= PW'(a_r) * PW'($signed(tw_im_s));
        pr_bc_r <= PW'(b_r) * PW'($signed(tw_re_s));
      end else begin
        pr_ac_r <= pr_ac_r;
        pr_bd_r <= pr_bd_r;
        pr_ad_r <= pr_ad_r;
        pr_bc_r <= pr_bc_r;
      end
    end
  end

  // P3 datapath: combine, optionally round, and scale back from Q2.x.
  always_comb begin
    sum_re_s = SW'(pr_ac_r) - SW'(pr_bd_r) + RND;
    sum_im_s = SW'(pr_ad_r) + SW'(pr_bc_r) + RND;
    shr_re_s = sum_re_s >>> SHIFT;
    shr_im_s = sum_im_s >>> SHIFT;
  end

  // P3 register: saturated outputs, held between valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_en  <= 1'b0;
      do_sof <= 1'b0;
      do_re  <= {DATA_WIDTH{1'b0}};
      do_im  <= {DATA_WIDTH{1'b0}};
    end else begin
      do_en  <= v2_r;
      do_sof <= sof2_r;
      if (v2_r) begin
        do_re <= sat_f(shr_re_s);
        do_im <= sat_f(shr_im_s);
      end else begin
        do_re <= do_re;
        do_im <= do_im;
      end
    end
  end

endmodule

// File: tb/tb_sdf_twiddle_mul.sv
// ---------------------------------------------------------------------------
// tb_sdf_twiddle_mul
// Self-checking bench for sdf_twiddle_mul (FFT_N=16, STAGE=0, 16/16 widths).
// A reference model derives each sample's frame position, twiddle and result
// with plain integer/real arithmetic; outputs are compared 1 time unit after
// every rising edge. Honors TWIDDLE_ROUND_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sdf_twiddle_mul;

  localparam int  FFT_N = 16;
  localparam int  STAGE = 0;
  localparam real PI    = 3.14159265358979323846;
  localparam real ONE   = 16384.0;

  typedef struct {
    int   re;
    int   im;
    logic sof;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        di_en;
  logic [15:0] di_re;
  logic [15:0] di_im;
  logic        do_en;
  logic [15:0] do_re;
  logic [15:0] do_im;
  logic        do_sof;

  int   checks;
  int   errors;
  int   mk;
  logic [2:0] vsh;
  exp_t exp_q [$];
  logic cur_en;
  logic cur_sof;
  int   cur_re;
  int   cur_im;

  sdf_twiddle_mul #(
    .FFT_N     (FFT_N),
    .STAGE     (STAGE),
    .DATA_WIDTH(16),
    .TW_WIDTH  (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .di_en (di_en),
    .di_re (di_re),
    .di_im (di_im),
    .do_en (do_en),
    .do_re (do_re),
    .do_im (do_im),
    .do_sof(do_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  // Reference: position -> exponent -> twiddle -> rotated, scaled sample.
  function automatic void model(input int k, input int a, input int b, output int ore, output int oim);
    int  m, j, e, c, d, pr, pi;
    real ang;
    m   = FFT_N >> STAGE;
    j   = k % m;
    e   = (j < m / 2) ? 0 : ((j - m / 2) << STAGE);
    ang = 2.0 * PI * real'(e) / real'(FFT_N);
    c   = $rtoi($floor(ONE * $cos(ang) + 0.5));
    d   = $rtoi($floor(-ONE * $sin(ang) + 0.5));
    pr  = a * c - b * d;
    pi  = a * d + b * c;
`ifdef TWIDDLE_ROUND_EN
    pr = pr + 8192;
    pi = pi + 8192;
`endif
    ore = sat16(pr >>> 14);
    oim = sat16(pi >>> 14);
  endfunction

  // Drive one cycle and advance the model's expectation of the outputs.
  task automatic tick(input logic r, input logic en, input int re, input int im);
    exp_t s;
    rst   = r;
    di_en = en;
    di_re = 16'(re);
    di_im = 16'(im);
    @(posedge clk);
    #1;
    if (r) begin
      vsh = 3'b000;
      exp_q.delete();
      mk = 0;
      cur_en = 1'b0; cur_sof = 1'b0; cur_re = 0; cur_im = 0;
    end else begin
      if (en) begin
        model(mk, re, im, s.re, s.im);
        s.sof = (mk == 0);
        exp_q.push_back(s);
        mk = (mk + 1) % FFT_N;
      end
      vsh = {vsh[1:0], en};
      cur_en  = vsh[2];
      cur_sof = 1'b0;
      if (vsh[2] && exp_q.size() > 0) begin
        s = exp_q.pop_front();
        cur_re = s.re; cur_im = s.im; cur_sof = s.sof;
      end
    end
  endtask

  function automatic int rnd_data();
    int v;
    v = int'($urandom_range(32'd9));
    if (v == 0) return -32768;
    else if (v == 1) return 32767;
    else return int'($urandom_range(32'd65535)) - 32768;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, rnd_data(), rnd_data());
      checks++;
      if (do_en !== 1'b0 || do_sof !== 1'b0 || do_re !== 16'd0 || do_im !== 16'd0) begin
        errors++;
        $display("FAIL reset cyc=%0d got en=%b sof=%b re=%0d im=%0d want all zero",
                 i, do_en, do_sof, $signed(do_re), $signed(do_im));
      end
    end
  endtask

  task automatic test_identity();
    int n;
    n = 0;
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, (i < 8), 1000, -500);
      checks++;
      if (do_en !== cur_en || do_sof !== cur_sof || do_re !== 16'(cur_re) || do_im !== 16'(cur_im)) begin
        errors++;
        $display("FAIL identity cyc=%0d got en=%b sof=%b re=%0d im=%0d want en=%b sof=%b re=%0d im=%0d",
                 i, do_en, do_sof, $signed(do_re), $signed(do_im), cur_en, cur_sof, cur_re, cur_im);
      end
      if (do_en === 1'b1) begin
        checks++;
        if ($signed(do_re) !== 16'sd1000 || $signed(do_im) !== -16'sd500 || do_sof !== (n == 0)) begin
          errors++;
          $display("FAIL identity_exact out=%0d got re=%0d im=%0d sof=%b want re=1000 im=-500",
                   n, $signed(do_re), $signed(do_im), do_sof);
        end
        n++;
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL identity_count got %0d outputs want 8", n);
    end
  endtask

  task automatic test_rotation();
    int n, a, b, want_re, want_im;
    n = 0;
    tick(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      a = rnd_data(); b = rnd_data();
      if (i == 10 || i == 12) begin a = 1000; b = 0; end
      if (i == 26) begin a = -32768; b = -32768; end
      tick(1'b0, (i < 27), a, b);
      checks++;
      if (do_en !== cur_en || do_sof !== cur_sof || do_re !== 16'(cur_re) || do_im !== 16'(cur_im)) begin
        errors++;
        $display("FAIL rotation cyc=%0d got en=%b sof=%b re=%0d im=%0d want en=%b sof=%b re=%0d im=%0d",
                 i, do_en, do_sof, $signed(do_re), $signed(do_im), cur_en, cur_sof, cur_re, cur_im);
      end
      if (do_en === 1'b1) begin
        if (n == 10 || n == 12 || n == 26) begin
          if (n == 10) begin
            want_re = 707;
`ifdef TWIDDLE_ROUND_EN
            want_im = -707;
`else
            want_im = -708;
`endif
          end else if (n == 12) begin
            want_re = 0; want_im = -1000;
          end else begin
            want_re = -32768; want_im = 0;
          end
          checks++;
          if (do_re !== 16'(want_re) || do_im !== 16'(want_im)) begin
            errors++;
            $display("FAIL rotation_exact out=%0d got re=%0d im=%0d want re=%0d im=%0d",
                     n, $signed(do_re), $signed(do_im), want_re, want_im);
          end
        end
        n++;
      end
    end
  endtask

  task automatic test_gaps_wrap();
    int n, cyc;
    logic en;
    n = 0;
    tick(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 51; i++) begin
      en = (i < 32) ? ((i % 2) == 0) : (i < 48);
      tick(1'b0, en, rnd_data(), rnd_data());
      checks++;
      if (do_en !== cur_en || do_sof !== cur_sof || do_re !== 16'(cur_re) || do_im !== 16'(cur_im)) begin
        errors++;
        $display("FAIL gaps cyc=%0d got en=%b sof=%b re=%0d im=%0d want en=%b sof=%b re=%0d im=%0d",
                 i, do_en, do_sof, $signed(do_re), $signed(do_im), cur_en, cur_sof, cur_re, cur_im);
      end
      if (do_en === 1'b1) begin
        checks++;
        if (do_sof !== (n == 0 || n == 16)) begin
          errors++;
          $display("FAIL gaps_sof out=%0d got sof=%b want %b", n, do_sof, (n == 0 || n == 16));
        end
        n++;
      end
    end
    // Mid-frame reset: five samples, reset where k=5 would be, then restart.
    tick(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, rnd_data(), rnd_data());
    tick(1'b1, 1'b1, rnd_data(), rnd_data());
    n = 0;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, (i >= 3 && i < 7), rnd_data(), rnd_data());
      checks++;
      if (do_en !== cur_en || do_sof !== cur_sof || do_re !== 16'(cur_re) || do_im !== 16'(cur_im)) begin
        errors++;
        $display("FAIL midreset cyc=%0d got en=%b sof=%b re=%0d im=%0d want en=%b sof=%b re=%0d im=%0d",
                 i, do_en, do_sof, $signed(do_re), $signed(do_im), cur_en, cur_sof, cur_re, cur_im);
      end
      if (do_en === 1'b1) begin
        if (n == 0) cyc = i;
        checks++;
        if (do_sof !== (n == 0)) begin
          errors++;
          $display("FAIL midreset_sof out=%0d got sof=%b want %b", n, do_sof, (n == 0));
        end
        n++;
      end
    end
    checks++;
    if (n != 4 || cyc != 5) begin
      errors++;
      $display("FAIL midreset_timing got outputs=%0d first_cyc=%0d want outputs=4 first_cyc=5", n, cyc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(32'd99) == 32'd0), ($urandom_range(32'd3) != 32'd0), rnd_data(), rnd_data());
      checks++;
      if (do_en !== cur_en || do_sof !== cur_sof || do_re !== 16'(cur_re) || do_im !== 16'(cur_im)) begin
        errors++;
        $display("FAIL random cyc=%0d got en=%b sof=%b re=%0d im=%0d want en=%b sof=%b re=%0d im=%0d",
                 i, do_en, do_sof, $signed(do_re), $signed(do_im), cur_en, cur_sof, cur_re, cur_im);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; mk = 0; vsh = 3'b000;
    cur_en = 1'b0; cur_sof = 1'b0; cur_re = 0; cur_im = 0;
    rst = 1'b1; di_en = 1'b0; di_re = 16'd0; di_im = 16'd0;
    test_reset();
    test_identity();
    test_rotation();
    test_gaps_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdf_twiddle_mul.md
# sdf_twiddle_mul

Pipelined twiddle-factor multiplier placed directly downstream of a radix-2 SDF butterfly stage. It consumes that stage's single-path output stream, tracks each sample's position within the frame, and looks up the matching twiddle W_N^e from a ROM. It multiplies each sample by its twiddle and delivers the rotated stream to the next SDF stage. Streaming only: no backpressure, one sample per enabled cycle.

## Interface
- FFT_N, 64: FFT length in points; power of two, at least 4.
- STAGE, 0: index of the upstream butterfly stage; 0 is the first stage; valid range 0 to log2(FFT_N)-2.
- DATA_WIDTH, 16: two's-complement width of each data component.
- TW_WIDTH, 16: twiddle component width; format Q2.(TW_WIDTH-2), so 1.0 = 2^(TW_WIDTH-2).
- clk  in  1  master clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- di_en  in  1  input sample valid.
- di_re  in  DATA_WIDTH  input real part.
- di_im  in  DATA_WIDTH  input imaginary part.
- do_en  out  1  output sample valid.
- do_re  out  DATA_WIDTH  output real part.
- do_im  out  DATA_WIDTH  output imaginary part.
- do_sof  out  1  high with the do_en that carries frame position k=0.

## Operation
- Sample counter k, log2(FFT_N) bits:
  - Increments on each di_en cycle.
  - Wraps FFT_N-1 -> 0.
  - Holds when di_en is low.
- Twiddle exponent:
  - m = FFT_N >> STAGE; j = k mod m.
  - If j < m/2, e = 0; otherwise e = (j - m/2) << STAGE.
- Twiddle value: W = cos(2πe/FFT_N) - i·sin(2πe/FFT_N), each component rounded to nearest in Q2.(TW_WIDTH-2).
- Complex multiply, with inputs (a, b) and twiddle (c, d):
  - re = a·c - b·d; im = a·d + b·c.
  - Products are full width, DATA_WIDTH+TW_WIDTH bits.
  - Sums are DATA_WIDTH+TW_WIDTH+1 bits.
- Scaling:
  - Arithmetic right shift by TW_WIDTH-2.
  - Then saturate to the DATA_WIDTH signed range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Multiplication by e=0 (1.0) and e=FFT_N/4 (-i) must be bit-exact with respect to the input.
- No state machine beyond the counter and the valid pipeline. Reset is the only frame-alignment mechanism: the upstream stage and this block must leave reset together.

## Timing
- Latency is 3 cycles from di_en to do_en, fixed.
  - P1: input data registered; ROM address derived from k; registered twiddle output.
  - P2: four partial products registered.
  - P3: add/sub, optional round, shift and saturate; result registered to do_*.
- Valid path: do_en is di_en delayed exactly 3 cycles. do_sof is (di_en && k==0) delayed 3 cycles.
- Data registers capture only on the valid of their stage. Outputs hold their last value while do_en is low.
- Reset:
  - k = 0.
  - All pipeline valids, do_en and do_sof = 0.
  - do_re and do_im = 0.
- Reset mid-frame: in-flight samples are discarded, meaning no do_en for 3 cycles after rst deasserts unless new di_en arrives. The first di_en after reset is k=0.
- Gapped input (di_en low on arbitrary cycles) must not change which twiddle each sample receives.

## Configuration
- TWIDDLE_ROUND_EN defined: 2^(TW_WIDTH-3) is added to the sum before the shift (round half up).
- TWIDDLE_ROUND_EN undefined: plain truncation (floor).
- Latency is identical in both builds.

## Structure
- Shared package/header holds:
  - DATA_WIDTH and TW_WIDTH defaults, kept consistent with the global data-width define.
  - Helper function for log2.
  - Twiddle Q-format constant 2^(TW_WIDTH-2).
- Sub-module sdf_twiddle_rom:
  - Synchronous-read ROM with address e in 0 to FFT_N/2-1.
  - Outputs tw_re and tw_im.
  - Contents generated at elaboration from FFT_N and TW_WIDTH.

## Test plan
Default configuration: FFT_N=16, STAGE=0, 16/16 widths.
- Reset: hold rst 2 cycles with di_en=1 -> do_en=0, do_sof=0, do_re=do_im=0 throughout reset.
- Identity: k=0..7 with (1000, -500) -> the same values out, 3 cycles later.
- -i rotation: k=12 (e=4) with (1000, 0) -> (0, -1000).
- 45° rotation: k=10 (e=2) with (1000, 0):
  - With TWIDDLE_ROUND_EN -> (707, -707).
  - Without it -> (707, -708).
- Saturation: k=10 with (-32768, -32768) -> (-32768, 0).
- Gaps and wrap:
  - 16 samples with di_en toggling every other cycle, then 16 contiguous samples.
  - Required: do_sof on the 1st and 17th output.
  - Required: each output matches the golden model for its k.
  - Required: reset asserted at k=5 restarts the frame at k=0.
